register_serializer: RTL
========================

# register_serializer

Parallel-to-serial transmitter for the datapath's register words. It captures a DATA_WIDTH-bit word in one cycle through a load/ready handshake and shifts it out MSB first, one bit per clock, with framing strobes. It sits downstream of a `register` output (its `reg_out` drives `ser_in`), and is the read-out end of the parallel write path into that register.

## Interface
- DATA_WIDTH, 11, width of the parallel word and number of serial bits per frame
- clock  in  1  system clock, all state changes on rising edge
- ser_reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- ser_in  in  DATA_WIDTH  parallel word to transmit
- ser_load  in  1  load request; accepted only when ser_ready=1
- ser_ready  out  1  block idle, next ser_load will be accepted
- ser_out  out  1  current serial bit (0 when ser_valid=0)
- ser_valid  out  1  ser_out carries a frame bit this cycle
- ser_start  out  1  high with the first (MSB) bit of a frame only
- ser_done  out  1  one-cycle pulse in the cycle after the last bit

## Operation
- States: IDLE, SHIFT, DONE. Internal: shift register (DATA_WIDTH), bit counter (ceil(log2(DATA_WIDTH)) bits).
- Reset values: state=IDLE, shift register=0, counter=0, ser_ready=1, ser_out=0, ser_valid=0, ser_start=0, ser_done=0.
- IDLE: ser_ready=1. If ser_load=1 at an edge: shift register <= ser_in, counter <= DATA_WIDTH-1, state <= SHIFT.
- SHIFT: ser_valid=1, ser_ready=0, ser_out = shift register MSB. Each edge: shift left by one (zero fill), counter decrements. When counter=0 at an edge, state <= DONE.
- ser_start=1 only in the first SHIFT cycle (counter=DATA_WIDTH-1).
- DONE: ser_done=1, ser_valid=0, ser_ready=0; next edge state <= IDLE.
- ser_load outside IDLE is ignored; ser_in is not sampled outside the accepting edge (changes mid-frame do not affect the frame).
- ser_reset has priority over everything: at any state, reset edge forces reset values, aborted frame is dropped, no ser_done pulse.
- Reset and ser_load at the same edge: reset wins, nothing is loaded.
- ser_ready, ser_valid, ser_start, ser_done, ser_out are registered/state-decoded outputs; no combinational path from inputs to outputs.

## Timing
- Load accepted at edge k (IDLE, ser_load=1): cycle k+1 carries bit DATA_WIDTH-1 with ser_valid=1, ser_start=1.
- Cycle k+i carries bit DATA_WIDTH-i, i=1..DATA_WIDTH; for DATA_WIDTH=11 last bit (bit 0) in cycle k+11.
- ser_done=1 in cycle k+DATA_WIDTH+1 (k+12); ser_ready=1 from cycle k+DATA_WIDTH+2 (k+13).
- ser_ready low for exactly DATA_WIDTH+1 cycles per frame.
- ser_load held high continuously: one frame every DATA_WIDTH+2 clocks, word re-sampled at each accepting edge.
- ser_valid never high in IDLE or DONE; exactly DATA_WIDTH valid cycles per completed frame.

## Test plan
- Reset: assert ser_reset 2 cycles with ser_load=1, ser_in=11'b11111111111 -> all outputs at reset values, ser_ready=1, no frame starts.
- Single frame: ser_in=11'b00000110010, ser_load pulse 1 cycle -> ser_out sequence 0,0,0,0,0,1,1,0,0,1,0 on 11 consecutive ser_valid cycles, ser_start on first only, ser_done one cycle later, ser_ready back 13 cycles after load edge.
- Input change mid-frame: load 11'b10110010010, change ser_in to 11'b11000010011 after 3 bits and pulse ser_load -> serial stream still 1,0,1,1,0,0,1,0,0,1,0; extra load ignored, single ser_done.
- Back-to-back: ser_load held high, ser_in=11'b11100000011 -> frames of 1,1,1,0,0,0,0,0,0,1,1 repeating every 13 cycles, one ser_done per frame.
- Reset mid-frame: load 11'b00010010000, assert ser_reset after 5 bits -> next cycle ser_valid=0, ser_out=0, ser_ready=1, no ser_done; subsequent load of 11'b00000110010 transmits correctly.
- Reset with load at same edge in IDLE: ser_reset=1, ser_load=1 -> no frame; after release, ser_ready=1 and ser_valid stays 0 until a new ser_load.

Source files
------------

// File: rtl/register_serializer.sv
// Parallel-to-serial transmitter: captures a DATA_WIDTH-bit word through a
// load/ready handshake and shifts it out MSB first with start/done strobes.
module register_serializer #(
  parameter int unsigned DATA_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  ser_reset,
  input  logic [DATA_WIDTH-1:0] ser_in,
  input  logic                  ser_load,
  output logic                  ser_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_start,
  output logic                  ser_done
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // State, shift register and bit counter; reset wins over any load.
  always_ff @(posedge clock) begin
    if (ser_reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: word is sampled only on the accepting edge in idle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ser_load) begin
          shift_d = ser_in;
          cnt_d   = CntLast;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded purely from registered state; no input-to-output path.
  always_comb begin
    ser_ready = (state_q == StIdle);
    ser_valid = (state_q == StShift);
    ser_done  = (state_q == StDone);
    ser_out   = ser_valid & shift_q[DATA_WIDTH-1];
    ser_start = ser_valid & (cnt_q == CntLast);
  end

endmodule
